// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared definitions for the register-file write-back front end.
// Widths default to those of the 8x32 register file.
package rf_writeback_arbiter_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 3;
    localparam int unsigned WB_DEPTH  = 4;

    typedef struct packed {
        logic                 live;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// Circular buffer of pending load returns {live, addr, data} with a
// kill-by-address port that clears live on every matching entry.
module rf_writeback_arbiter_wb_fifo
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DEPTH  = WB_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         i_push,
    input  logic                         i_push_live,
    input  logic [ADDR_W-1:0]            i_push_addr,
    input  logic [DATA_W-1:0]            i_push_data,
    input  logic                         i_pop,
    input  logic                         i_kill,
    input  logic [ADDR_W-1:0]            i_kill_addr,
    output logic [CNT_W-1:0]             o_count,
    output logic                         o_head_live,
    output logic [ADDR_W-1:0]            o_head_addr,
    output logic [DATA_W-1:0]            o_head_data,
    output logic [DEPTH-1:0]             o_live,
    output logic [DEPTH-1:0][ADDR_W-1:0] o_addr
);

    logic [DEPTH-1:0]  r_live;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    // Popped slots drop live so pend_mask can OR over all slots without an occupancy mask.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_live  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && (r_addr[i] == i_kill_addr)) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (i_pop) begin
                r_live[r_rptr] <= 1'b0;
                r_rptr         <= r_rptr + 1'b1;
            end
            if (i_push) begin
                r_live[r_wptr] <= i_push_live;
                r_addr[r_wptr] <= i_push_addr;
                r_data[r_wptr] <= i_push_data;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_head_live = r_live[r_rptr];
    assign o_head_addr = r_addr[r_rptr];
    assign o_head_data = r_data[r_rptr];
    assign o_live      = r_live;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_addr[i] = r_addr[i];
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges in-order ALU results and buffered out-of-order load returns onto the
// single register-file write port; ALU always wins and kills stale loads.
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DEPTH  = WB_DEPTH,
    localparam int unsigned NREG  = 1 << ADDR_W,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              wena,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [NREG-1:0]   pend_mask,
    output logic [CNT_W-1:0]  ld_count
);

    logic [CNT_W-1:0]             w_count;
    logic                         w_head_live;
    logic [ADDR_W-1:0]            w_head_addr;
    logic [DATA_W-1:0]            w_head_data;
    logic [DEPTH-1:0]             w_live;
    logic [DEPTH-1:0][ADDR_W-1:0] w_addr_vec;
    logic                         w_push;
    logic                         w_push_live;
    logic                         w_pop;

    logic                         r_wena;
    logic [ADDR_W-1:0]            r_waddr;
    logic [DATA_W-1:0]            r_wdata;

    // Ready follows the registered count only; a same-cycle pop does not free a slot early.
    assign ld_ready    = (w_count != CNT_W'(DEPTH));
    assign w_push      = ld_valid && ld_ready;
    // The ALU result is younger than a load arriving in the same cycle.
    assign w_push_live = !(alu_valid && (ld_addr == alu_addr));
    assign w_pop       = !alu_valid && (w_count != '0);

    rf_writeback_arbiter_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .clr         (clr),
        .i_push      (w_push),
        .i_push_live (w_push_live),
        .i_push_addr (ld_addr),
        .i_push_data (ld_data),
        .i_pop       (w_pop),
        .i_kill      (alu_valid),
        .i_kill_addr (alu_addr),
        .o_count     (w_count),
        .o_head_live (w_head_live),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_live      (w_live),
        .o_addr      (w_addr_vec)
    );

    // A killed head is consumed with wena low.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wena  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (alu_valid) begin
            r_wena  <= 1'b1;
            r_waddr <= alu_addr;
            r_wdata <= alu_data;
        end else if (w_pop) begin
            r_wena  <= w_head_live;
            r_waddr <= w_head_addr;
            r_wdata <= w_head_data;
        end else begin
            r_wena  <= 1'b0;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live[i]) begin
                pend_mask[w_addr_vec[i]] = 1'b1;
            end
        end
    end

    assign wena     = r_wena;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign ld_count = w_count;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_rf_writeback_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              clr;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              wena;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        pend_mask;
    logic [2:0]        ld_count;

    always #5 clk = ~clk;

    rf_writeback_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .wena      (wena),
        .waddr     (waddr),
        .wdata     (wdata),
        .pend_mask (pend_mask),
        .ld_count  (ld_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: buffered loads as an ordered queue, plus the expected port value.
    typedef struct {
        bit          live;
        int          addr;
        logic [31:0] data;
    } ment_t;
    ment_t       mq[$];
    bit          m_wena;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          model_chk;

    // Program-order register file vs. the one rebuilt from observed port writes.
    logic [31:0] gold_rf [8];
    logic [31:0] seen_rf [8];
    logic [35:0] wr_log[$];

    typedef struct {
        bit          av;
        logic [2:0]  aa;
        logic [31:0] ad;
        bit          lv;
        logic [2:0]  la;
        logic [31:0] ld;
        bit          ew;
        logic [2:0]  ea;
        logic [31:0] ed;
        int          ecnt;
        logic [7:0]  epend;
        bit          erdy;
    } vec_t;
    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_pend();
        logic [7:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mk(bit av, int aa, logic [31:0] ad, bit lv, int la,
                                logic [31:0] ld, bit ew, int ea, logic [31:0] ed,
                                int ecnt, logic [7:0] epend, bit erdy);
        vec_t v;
        v.av = av; v.aa = 3'(aa); v.ad = ad; v.lv = lv; v.la = 3'(la); v.ld = ld;
        v.ew = ew; v.ea = 3'(ea); v.ed = ed; v.ecnt = ecnt; v.epend = epend; v.erdy = erdy;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wena  = 1'b0;
        m_waddr = 0;
        m_wdata = '0;
    endtask

    task automatic step(input bit av, input int aa, input logic [31:0] ad,
                        input bit lv, input int la, input logic [31:0] ld);
        bit    rdy;
        ment_t h;
        alu_valid = av;
        alu_addr  = 3'(aa);
        alu_data  = ad;
        ld_valid  = lv;
        ld_addr   = 3'(la);
        ld_data   = ld;
        rdy = (mq.size() != DEPTH);
        if (lv && rdy) gold_rf[la] = ld;
        if (av) gold_rf[aa] = ad;
        if (av) begin
            m_wena = 1'b1; m_waddr = aa; m_wdata = ad;
            foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_wena = h.live;
            if (h.live) begin m_waddr = h.addr; m_wdata = h.data; end
        end else begin
            m_wena = 1'b0;
        end
        if (lv && rdy) begin
            h.live = !(av && (la == aa));
            h.addr = la;
            h.data = ld;
            mq.push_back(h);
        end
        @(posedge clk);
        #1;
        if (wena) begin
            seen_rf[waddr] = wdata;
            wr_log.push_back({1'b0, waddr, wdata});
        end
        if (model_chk) begin
            chk("m.wena", wena, m_wena);
            if (m_wena) begin
                chk("m.waddr", waddr, m_waddr);
                chk("m.wdata", wdata, m_wdata);
            end
            chk("m.ld_count", ld_count, mq.size());
            chk("m.pend_mask", pend_mask, model_pend());
            chk("m.ld_ready", ld_ready, mq.size() != DEPTH);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        alu_valid = 0; ld_valid = 0;
        clr = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        model_chk = 0;
        model_reset();
        for (int r = 0; r < 8; r++) begin gold_rf[r] = '0; seen_rf[r] = '0; end

        // Power-on reset
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wena", wena, 0);
        chk("rst.waddr", waddr, 0);
        chk("rst.wdata", wdata, 0);
        chk("rst.ld_count", ld_count, 0);
        chk("rst.pend_mask", pend_mask, 0);
        chk("rst.ld_ready", ld_ready, 1);
        clr = 1'b0;

        // Directed vectors; expectations are the values after the edge.
        tbl[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0,     1, 3, 32'hDEADBEEF, 0, 8'h00, 1);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 0,            0, 8'h00, 1);
        tbl[2]  = mk(1, 7, 32'h70,       1, 1, 32'h11, 1, 7, 32'h70,      1, 8'h02, 1);
        tbl[3]  = mk(1, 7, 32'h71,       1, 2, 32'h22, 1, 7, 32'h71,      2, 8'h06, 1);
        tbl[4]  = mk(1, 7, 32'h72,       1, 3, 32'h33, 1, 7, 32'h72,      3, 8'h0E, 1);
        tbl[5]  = mk(1, 7, 32'h73,       1, 4, 32'h44, 1, 7, 32'h73,      4, 8'h1E, 0);
        tbl[6]  = mk(0, 0, 0,            1, 6, 32'h66, 1, 1, 32'h11,      3, 8'h1C, 1);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,     1, 2, 32'h22,       2, 8'h18, 1);
        tbl[8]  = mk(0, 0, 0,            0, 0, 0,     1, 3, 32'h33,       1, 8'h10, 1);
        tbl[9]  = mk(0, 0, 0,            0, 0, 0,     1, 4, 32'h44,       0, 8'h00, 1);
        tbl[10] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0,            0, 8'h00, 1);
        tbl[11] = mk(0, 0, 0,            1, 5, 32'hAAAA, 0, 0, 0,         1, 8'h20, 1);
        tbl[12] = mk(1, 5, 32'hBBBB,     0, 0, 0,     1, 5, 32'hBBBB,     1, 8'h00, 1);
        tbl[13] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0,            0, 8'h00, 1);
        tbl[14] = mk(1, 2, 32'h2,        1, 2, 32'h1, 1, 2, 32'h2,        1, 8'h00, 1);
        tbl[15] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0,            0, 8'h00, 1);
        tbl[16] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0,            0, 8'h00, 1);
        for (int i = 0; i < NV; i++) begin
            step(tbl[i].av, int'(tbl[i].aa), tbl[i].ad, tbl[i].lv, int'(tbl[i].la), tbl[i].ld);
            chk($sformatf("v%0d.wena", i), wena, tbl[i].ew);
            if (tbl[i].ew) begin
                chk($sformatf("v%0d.waddr", i), waddr, tbl[i].ea);
                chk($sformatf("v%0d.wdata", i), wdata, tbl[i].ed);
            end
            chk($sformatf("v%0d.ld_count", i), ld_count, tbl[i].ecnt);
            chk($sformatf("v%0d.pend_mask", i), pend_mask, tbl[i].epend);
            chk($sformatf("v%0d.ld_ready", i), ld_ready, tbl[i].erdy);
        end

        // Reset mid-operation with three loads buffered behind ALU traffic
        model_chk = 1;
        step(1, 7, 32'h77, 1, 1, 32'h101);
        step(1, 7, 32'h78, 1, 2, 32'h102);
        step(1, 7, 32'h79, 1, 3, 32'h103);
        chk("mid.ld_count_before", ld_count, 3);
        alu_valid = 0; ld_valid = 0;
        clr = 1'b1;
        model_reset();
        #1;
        chk("mid.wena", wena, 0);
        chk("mid.ld_count", ld_count, 0);
        chk("mid.pend_mask", pend_mask, 0);
        chk("mid.ld_ready", ld_ready, 1);
        @(posedge clk);
        #1;
        clr = 1'b0;
        wr_log.delete();
        idle(5);
        chk("mid.no_write_after", wr_log.size(), 0);

        // Wrap with concurrent push/pop: ten back-to-back loads, no ALU traffic
        wr_log.delete();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, i % 8, 32'h100 + i);
            chk("wrap.count_le1", ld_count <= 1, 1);
            chk("wrap.ld_ready", ld_ready, 1);
        end
        idle(2);
        chk("wrap.nwrites", wr_log.size(), 10);
        for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
            chk($sformatf("wrap.w%0d", i), wr_log[i], {1'b0, 3'(i % 8), 32'h100 + i});
        end

        // Randomized traffic with periodic ALU bursts to exercise back-pressure
        do_reset();
        for (int r = 0; r < 8; r++) begin gold_rf[r] = '0; seen_rf[r] = '0; end
        for (int c = 0; c < 1500; c++) begin
            int  pa;
            bit  av;
            bit  lv;
            pa = ((c % 64) < 12) ? 100 : 35;
            av = ($urandom_range(0, 99) < pa);
            lv = ($urandom_range(0, 99) < 60);
            step(av, $urandom_range(0, 7), $urandom(), lv, $urandom_range(0, 7), $urandom());
        end
        idle(DEPTH + 4);
        chk("rand.drained", ld_count, 0);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("rand.rf%0d", r), seen_rf[r], gold_rf[r]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
